divby_mersenne: RTL and testbench
=================================

# divby_mersenne

Sequential divider by a Mersenne constant D = 2^K − 1, the parametrised successor of our fixed divide-by-255 lab unit. Accepts an N-bit dividend as NCHUNK chunks of CW bits over a valid/ready input port, divides by bit-serial restoring division, and returns the quotient chunks followed by the remainder over a valid/ready output port. It is a datapath leaf for the lab processor's arithmetic experiments.

## Interface
- CW, 16, chunk width in bits; sets both input and output chunk width.
- NCHUNK, 2, dividend and quotient chunk count; N = CW*NCHUNK.
- K, 8, divisor exponent, D = 2^K − 1; legal range 2 ≤ K ≤ CW.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a dividend chunk.
- in_data  in  CW  dividend chunk, most-significant chunk first.
- in_ready  out  1  block accepts a chunk this cycle.
- out_valid  out  1  out_data holds a result chunk.
- out_data  out  CW  quotient chunk, MSB chunk first, then remainder zero-extended from K bits.
- out_last  out  1  current out_data is the remainder chunk.
- out_ready  in  1  consumer takes out_data this cycle.
- busy  out  1  state is CALC or OUT.

## Operation
- State machine LOAD → CALC → OUT → LOAD.
- LOAD: in_ready = 1. Each in_valid&&in_ready cycle shifts in_data into the dividend register from the LSB side: dividend ← {dividend[N−CW−1:0], in_data}. A chunk counter counts 0..NCHUNK−1. Accepting chunk NCHUNK−1 moves to CALC and clears the partial remainder and bit counter.
- CALC: one quotient bit per cycle, N cycles, MSB first.
  - The partial remainder r is K+1 bits wide.
  - t = {r[K−1:0], dividend MSB}.
  - If t ≥ D: r ← t − D and qbit = 1. Otherwise r ← t and qbit = 0.
  - The dividend shifts left with qbit entering the LSB, so the register ends holding the quotient.
  - After N cycles, r < D. Move to OUT with the output index at 0.
- OUT: out_valid = 1.
  - For index i < NCHUNK, out_data = quotient chunk i, counting from the most-significant chunk.
  - For index NCHUNK, out_data = {(CW−K) zeros, r[K−1:0]} and out_last = 1.
  - The index advances on out_valid&&out_ready.
  - A handshake on the last chunk returns to LOAD.
- in_ready = 0 in CALC and OUT; input chunks offered then are not consumed.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- Dividend 0 gives all-zero quotient and remainder. A dividend that is an exact multiple of D gives remainder 0, never D.

## Timing
- Reset (async assert, any state): state=LOAD, chunk, bit and output counters = 0, dividend = 0, r = 0.
- Output values during reset: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
- Reset asserted mid-CALC or mid-OUT abandons the operation; no partial output follows.
- in_ready, out_valid, out_last and busy are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Latency: last input chunk accepted at edge t; CALC occupies edges t+1..t+N; out_valid=1 from after edge t+N.
- With out_ready held 1, output takes NCHUNK+1 cycles and in_ready=1 on the cycle after the last output handshake.
- Throughput: one operation per NCHUNK + N + NCHUNK + 1 cycles minimum.
- Back-to-back: the next LOAD starts the cycle after the last output handshake, with no idle cycle.
- in_valid gaps in LOAD and out_ready stalls in OUT of any length are legal.

## Test plan
- Default parameters, chunks 0x0000, 0x639C (25500) → quotient chunks 0x0000, 0x0064; remainder 0x0000 with out_last=1; out_valid rises exactly N=32 cycles after the last input handshake.
- Chunks 0x0003, 0xE418 (255000) → 0x0000, 0x03E8, 0x0000. Chunks 0xFFFF, 0xFFFF → 0x0101, 0x0101, 0x0000.
- Boundary operands: 254 → quotient 0, remainder 0x00FE; 255 → quotient 1, remainder 0; 256 → quotient 1, remainder 1; 0 → all zeros.
- Handshake stress:
  - in_valid toggling randomly in LOAD, and in_valid held high during CALC/OUT, which must not be consumed.
  - out_ready low for 5 cycles mid-output, with out_data held stable.
  - Two operations back-to-back.
- Reset stress: deassert rst_n in the 10th CALC cycle, then again during OUT index 1. Each time, outputs return to reset values immediately, and a fresh 25500 operation then completes correctly.
- Parameter sweep CW=8, NCHUNK=3, K=4 (D=15):
  - 100 → 0x00, 0x00, 0x06, remainder 0x0A.
  - 0xFFFFFF → 0x11, 0x11, 0x11, remainder 0x00.
  - Random operands checked against a reference model of / and % by D.

Source files
------------

// File: rtl/divby_mersenne.sv
// Sequential divider by D = 2^K - 1.
// Takes the dividend as NCHUNK chunks of CW bits, MSB chunk first. Runs a bit-serial restoring
// division, one quotient bit per cycle. Returns the quotient chunks, MSB chunk first, then the
// remainder as a final chunk flagged with o_out_last.
module divby_mersenne #(
  parameter int unsigned CW     = 16,
  parameter int unsigned NCHUNK = 2,
  parameter int unsigned K      = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  input  logic [CW-1:0] i_in_data,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [CW-1:0] o_out_data,
  output logic          o_out_last,
  input  logic          i_out_ready,
  output logic          o_busy
);

  localparam int unsigned N    = CW * NCHUNK;
  localparam int unsigned CNTW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IDXW = $clog2(NCHUNK + 1);
  localparam int unsigned BITW = $clog2(N);
  localparam logic [K:0]  D    = {1'b0, {K{1'b1}}};

  typedef enum logic [1:0] {
    StLoad,
    StCalc,
    StOut
  } state_e;

  state_e          r_state;
  logic [CNTW-1:0] r_chunk_cnt;
  logic [BITW-1:0] r_bit_cnt;
  logic [IDXW-1:0] r_out_idx;
  logic [N-1:0]    r_dividend;
  // Partial remainder. It stays below D between steps, so its top bit is always zero and is
  // not stored. The full K+1-bit value exists only as w_t.
  logic [K-1:0]    r_rem;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic [CW-1:0]   r_out_data;

  logic [K:0]      w_t;
  logic [K:0]      w_diff;
  logic            w_qbit;
  logic [K-1:0]    w_rem_next;
  logic [N-1:0]    w_div_shift;
  logic [N-1:0]    w_div_load;
  logic [CW-1:0]   w_rem_chunk;
  logic [CW-1:0]   w_next_chunk;

  // One restoring-division step, plus the chunk-load and output-select datapaths.
  always_comb begin
    w_t        = {r_rem, r_dividend[N-1]};
    w_diff     = w_t - D;
    // t never exceeds 2D-1. So t-D fits in K bits when t >= D. A borrow sets bit K exactly when
    // t < D.
    w_qbit      = ~w_diff[K];
    w_rem_next  = w_qbit ? w_diff[K-1:0] : w_t[K-1:0];
    w_div_shift = {r_dividend[N-2:0], w_qbit};
    w_div_load  = (r_dividend << CW) | N'(i_in_data);
    w_rem_chunk = CW'(r_rem);
    w_next_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (IDXW'(i) == r_out_idx + IDXW'(1)) begin
        w_next_chunk = r_dividend[(NCHUNK - 1 - i) * CW +: CW];
      end
    end
  end

  // Control FSM with registered handshake, status and data outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StLoad;
      r_chunk_cnt <= '0;
      r_bit_cnt   <= '0;
      r_out_idx   <= '0;
      r_dividend  <= '0;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        StLoad: begin
          if (i_in_valid && r_in_ready) begin
            r_dividend <= w_div_load;
            if (r_chunk_cnt == CNTW'(NCHUNK - 1)) begin
              r_state     <= StCalc;
              r_chunk_cnt <= '0;
              r_rem       <= '0;
              r_bit_cnt   <= '0;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_chunk_cnt <= r_chunk_cnt + CNTW'(1);
            end
          end
        end
        StCalc: begin
          r_dividend <= w_div_shift;
          r_rem      <= w_rem_next;
          if (r_bit_cnt == BITW'(N - 1)) begin
            r_state     <= StOut;
            r_out_idx   <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_out_data  <= w_div_shift[N-1 -: CW];
          end else begin
            r_bit_cnt <= r_bit_cnt + BITW'(1);
          end
        end
        StOut: begin
          if (i_out_ready) begin
            if (r_out_idx == IDXW'(NCHUNK)) begin
              r_state     <= StLoad;
              r_out_idx   <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= '0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else if (r_out_idx == IDXW'(NCHUNK - 1)) begin
              r_out_idx  <= r_out_idx + IDXW'(1);
              r_out_data <= w_rem_chunk;
              r_out_last <= 1'b1;
            end else begin
              r_out_idx  <= r_out_idx + IDXW'(1);
              r_out_data <= w_next_chunk;
            end
          end
        end
        default: begin
          r_state <= StLoad;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_divby_mersenne.sv
// Scoreboard bench for divby_mersenne: default instance (D=255) plus a CW=8/NCHUNK=3/K=4 instance.
module tb_divby_mersenne;

  localparam int CW  = 16;
  localparam int NC  = 2;
  localparam int KK  = 8;
  localparam int N   = CW * NC;
  localparam longint unsigned D  = 255;
  localparam int SCW = 8;
  localparam int SNC = 3;
  localparam int SK  = 4;
  localparam longint unsigned SD = 15;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  logic           s_in_valid;
  logic [SCW-1:0] s_in_data;
  logic           s_in_ready;
  logic           s_out_valid;
  logic [SCW-1:0] s_out_data;
  logic           s_out_last;
  logic           s_out_ready;
  logic           s_busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test sequence
  exp_t exp_q[$];
  exp_t s_exp_q[$];

  divby_mersenne #(.CW(CW), .NCHUNK(NC), .K(KK)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .o_out_last (out_last),
    .i_out_ready(out_ready),
    .o_busy     (busy)
  );

  divby_mersenne #(.CW(SCW), .NCHUNK(SNC), .K(SK)) u_dut_s (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (s_in_valid),
    .i_in_data  (s_in_data),
    .o_in_ready (s_in_ready),
    .o_out_valid(s_out_valid),
    .o_out_data (s_out_data),
    .o_out_last (s_out_last),
    .i_out_ready(s_out_ready),
    .o_busy     (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // Reference model: plain integer / and % by D.
  task automatic push_main(input logic [31:0] dv);
    longint unsigned q, r;
    exp_t e;
    q = longint'(dv) / D;
    r = longint'(dv) % D;
    for (int i = 0; i < NC; i++) begin
      e.d = 16'(q >> (CW * (NC - 1 - i)));
      e.l = 1'b0;
      exp_q.push_back(e);
    end
    e.d = 16'(r);
    e.l = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(input logic [23:0] dv);
    longint unsigned q, r;
    exp_t e;
    q = longint'(dv) / SD;
    r = longint'(dv) % SD;
    for (int i = 0; i < SNC; i++) begin
      e.d = {8'h00, 8'(q >> (SCW * (SNC - 1 - i)))};
      e.l = 1'b0;
      s_exp_q.push_back(e);
    end
    e.d = 16'(r);
    e.l = 1'b1;
    s_exp_q.push_back(e);
  endtask

  // out_ready / s_out_ready drivers
  initial begin
    out_ready   = 1'b1;
    s_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom % 3) != 0;
      s_out_ready = ($urandom % 2) != 0;
    end
  end

  // Main monitor: scoreboard pops, stall stability, ready-after-last.
  logic [15:0] hold_d;
  logic        hold_l;
  bit          hold_v = 0;
  bit          after_last = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v     = 0;
      after_last = 0;
    end else begin
      if (hold_v) begin
        chk("stall_data", 32'(out_data), 32'(hold_d));
        chk("stall_last", 32'(out_last), 32'(hold_l));
      end
      if (after_last) chk("ready_after_last", {30'b0, in_ready, out_valid}, 32'b10);
      hold_v     = 0;
      after_last = 0;
      if (out_valid) chk("out_phase_flags", {30'b0, busy, in_ready}, 32'b10);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_last", 32'(out_last), 32'(e.l));
        end
        after_last = out_last;
      end else if (out_valid) begin
        hold_v = 1;
        hold_d = out_data;
        hold_l = out_last;
      end
    end
  end

  // Latency: out_valid must rise N edges after the edge that takes the last input chunk.
  int in_hs_cnt = 0;
  int t_last_hs = 0;
  bit lat_armed = 0;
  bit prev_ov = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_hs_cnt = 0;
      lat_armed = 0;
      prev_ov   = 0;
    end else begin
      if (out_valid && !prev_ov && lat_armed) begin
        chk("latency", 32'(cyc - t_last_hs), 32'(N));
        lat_armed = 0;
      end
      if (in_valid && in_ready) begin
        if (in_hs_cnt == NC - 1) begin
          in_hs_cnt = 0;
          t_last_hs = cyc + 1;
          lat_armed = 1;
        end else begin
          in_hs_cnt++;
        end
      end
      prev_ov = out_valid;
    end
  end

  // Sweep-instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        fail_now("s_unexpected_output");
      end else begin
        e = s_exp_q.pop_front();
        chk("s_out_data", 32'(s_out_data), 32'(e.d));
        chk("s_out_last", 32'(s_out_last), 32'(e.l));
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_in_ready", 32'(s_in_ready), 32'd1);
    chk("rst_s_out_valid", 32'(s_out_valid), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    exp_q.delete();
    s_exp_q.delete();
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_chunk(input logic [CW-1:0] data);
    int n = 0;
    in_valid = 1'b1;
    in_data  = data;
    while (!in_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [31:0] dv, input bit gaps, input bit hold);
    int n = 0;
    push_main(dv);
    for (int c = 0; c < NC; c++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          in_data  = 16'($urandom);
          @(posedge clk);
          #1;
        end
      end
      send_chunk(dv[(NC - 1 - c) * CW +: CW]);
    end
    if (hold) begin
      // Offer garbage while busy; dropped once the remainder chunk is showing.
      while (!(out_valid && out_last) && n < 2000) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 2000) fail_now("hold_timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic s_send_op(input logic [23:0] dv);
    int n;
    push_sweep(dv);
    for (int c = 0; c < SNC; c++) begin
      repeat ($urandom_range(0, 2)) begin
        s_in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_in_valid = 1'b1;
      s_in_data  = dv[(SNC - 1 - c) * SCW +: SCW];
      n = 0;
      while (!s_in_ready && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 2000) fail_now("s_in_ready_timeout");
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || s_exp_q.size() > 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now("out_valid_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    #2;
    apply_reset();

    // Directed operands, then back-to-back and boundary values.
    rdy_mode = 0;
    send_op(32'd25500, 1'b0, 1'b0);
    drain();
    send_op(32'd255000, 1'b0, 1'b0);
    send_op(32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();
    send_op(32'd254, 1'b0, 1'b0);
    send_op(32'd255, 1'b0, 1'b0);
    send_op(32'd256, 1'b0, 1'b0);
    send_op(32'd0, 1'b0, 1'b0);
    drain();

    // Random operands, in_valid gaps, garbage offered while busy, random out_ready.
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] dv;
      dv = (i % 4 == 3) ? 32'(longint'($urandom_range(0, 16843009)) * D) : $urandom;
      send_op(dv, 1'b1, (i % 2) == 0);
    end
    drain();

    // Five-cycle out_ready stall after the first output chunk.
    rdy_mode  = 2;
    out_ready = 1'b1;
    send_op(32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_out_valid();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    rdy_mode  = 0;
    drain();

    // Reset in the 10th CALC cycle, then a fresh operation.
    send_op(32'd25500, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("calc_busy", 32'(busy), 32'd1);
    apply_reset();
    send_op(32'd25500, 1'b0, 1'b0);
    drain();

    // Reset while output index 1 is showing, then a fresh operation.
    send_op(32'd25500, 1'b0, 1'b0);
    wait_out_valid();
    @(posedge clk);
    #1;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("no_output_after_reset", 32'(out_valid), 32'd0);
    send_op(32'd25500, 1'b0, 1'b0);
    drain();

    // CW=8, NCHUNK=3, K=4 instance.
    s_send_op(24'd100);
    s_send_op(24'hFF_FFFF);
    s_send_op(24'd15);
    s_send_op(24'd0);
    for (int i = 0; i < 24; i++) s_send_op(24'($urandom));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
